// File: rtl/pe_relay_pkg.sv
// Shared constants for the four-direction elastic relay tile.
// Direction indices select bits of every per-channel vector.
package pe_relay_pkg;
  localparam int DIR_EAST      = 0;
  localparam int DIR_WEST      = 1;
  localparam int DIR_NORTH     = 2;
  localparam int DIR_SOUTH     = 3;
  localparam int NUM_DIR       = 4;
  localparam int CNT_WIDTH_DEF = 16;
endpackage

// File: rtl/pe_relay_chan.sv
// One elastic relay channel: DEPTH-entry FIFO with valid/ready on both sides.
// PE_RELAY_STATS_EN adds a saturating pop counter on xfer_count.
module pe_relay_chan
  import pe_relay_pkg::*;
#(
  parameter int WIDTH     = 130,
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ap_start,
  input  logic                 en,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] xfer_count
);
  localparam int ADDR = $clog2(DEPTH);
  localparam logic [ADDR:0] FULL_OCC = (ADDR+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR-1:0]  wr_ptr;
  logic [ADDR-1:0]  rd_ptr;
  logic [ADDR:0]    occ;
  logic             full;
  logic             push;
  logic             pop;

  assign full      = (occ == FULL_OCC);
  assign in_ready  = ap_start & en & ~full & ~reset;
  assign out_valid = en & (occ != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Disabling the channel discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

`ifdef PE_RELAY_STATS_EN
  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (pop && cnt != '1)
      cnt <= cnt + 1'b1;
  end

  assign xfer_count = cnt;
`else
  assign xfer_count = '0;
`endif
endmodule

// File: rtl/pe_relay_hs.sv
// Mesh relay PE: four independent elastic pass-through channels.
// Optional statistics counters are enabled with PE_RELAY_STATS_EN.
module pe_relay_hs
  import pe_relay_pkg::*;
#(
  parameter int EAST_WIDTH  = 130,
  parameter int WEST_WIDTH  = 130,
  parameter int NORTH_WIDTH = 130,
  parameter int SOUTH_WIDTH = 130,
  parameter int DEPTH       = 2,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ap_start,
  input  logic [NUM_DIR-1:0]           chan_en,
  input  logic [EAST_WIDTH-1:0]        in_from_east,
  input  logic [WEST_WIDTH-1:0]        in_from_west,
  input  logic [NORTH_WIDTH-1:0]       in_from_north,
  input  logic [SOUTH_WIDTH-1:0]       in_from_south,
  input  logic [NUM_DIR-1:0]           in_valid,
  output logic [NUM_DIR-1:0]           in_ready,
  output logic [EAST_WIDTH-1:0]        out_to_east,
  output logic [WEST_WIDTH-1:0]        out_to_west,
  output logic [NORTH_WIDTH-1:0]       out_to_north,
  output logic [SOUTH_WIDTH-1:0]       out_to_south,
  output logic [NUM_DIR-1:0]           out_valid,
  input  logic [NUM_DIR-1:0]           out_ready,
  output logic [NUM_DIR*CNT_WIDTH-1:0] xfer_count
);
  pe_relay_chan #(
    .WIDTH(EAST_WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)
  ) u_east (
    .clk       (clk),
    .reset     (reset),
    .ap_start  (ap_start),
    .en        (chan_en[DIR_EAST]),
    .in_data   (in_from_east),
    .in_valid  (in_valid[DIR_EAST]),
    .in_ready  (in_ready[DIR_EAST]),
    .out_data  (out_to_east),
    .out_valid (out_valid[DIR_EAST]),
    .out_ready (out_ready[DIR_EAST]),
    .xfer_count(xfer_count[DIR_EAST*CNT_WIDTH +: CNT_WIDTH])
  );

  pe_relay_chan #(
    .WIDTH(WEST_WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)
  ) u_west (
    .clk       (clk),
    .reset     (reset),
    .ap_start  (ap_start),
    .en        (chan_en[DIR_WEST]),
    .in_data   (in_from_west),
    .in_valid  (in_valid[DIR_WEST]),
    .in_ready  (in_ready[DIR_WEST]),
    .out_data  (out_to_west),
    .out_valid (out_valid[DIR_WEST]),
    .out_ready (out_ready[DIR_WEST]),
    .xfer_count(xfer_count[DIR_WEST*CNT_WIDTH +: CNT_WIDTH])
  );

  pe_relay_chan #(
    .WIDTH(NORTH_WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)
  ) u_north (
    .clk       (clk),
    .reset     (reset),
    .ap_start  (ap_start),
    .en        (chan_en[DIR_NORTH]),
    .in_data   (in_from_north),
    .in_valid  (in_valid[DIR_NORTH]),
    .in_ready  (in_ready[DIR_NORTH]),
    .out_data  (out_to_north),
    .out_valid (out_valid[DIR_NORTH]),
    .out_ready (out_ready[DIR_NORTH]),
    .xfer_count(xfer_count[DIR_NORTH*CNT_WIDTH +: CNT_WIDTH])
  );

  pe_relay_chan #(
    .WIDTH(SOUTH_WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)
  ) u_south (
    .clk       (clk),
    .reset     (reset),
    .ap_start  (ap_start),
    .en        (chan_en[DIR_SOUTH]),
    .in_data   (in_from_south),
    .in_valid  (in_valid[DIR_SOUTH]),
    .in_ready  (in_ready[DIR_SOUTH]),
    .out_data  (out_to_south),
    .out_valid (out_valid[DIR_SOUTH]),
    .out_ready (out_ready[DIR_SOUTH]),
    .xfer_count(xfer_count[DIR_SOUTH*CNT_WIDTH +: CNT_WIDTH])
  );
endmodule

// File: tb/tb_pe_relay_hs.sv
// Directed bench for pe_relay_hs (DEPTH=2, CNT_WIDTH=4).
// Build with PE_RELAY_STATS_EN to check the saturating counters.
module tb_pe_relay_hs;
  logic         clk = 1'b0;
  logic         reset;
  logic         ap_start;
  logic [3:0]   chan_en;
  logic [3:0]   in_valid;
  logic [3:0]   out_ready;
  logic [3:0]   in_ready;
  logic [3:0]   out_valid;
  logic [129:0] d [4];
  logic [129:0] in_from_east, in_from_west, in_from_north, in_from_south;
  logic [129:0] out_to_east, out_to_west, out_to_north, out_to_south;
  logic [129:0] outs [4];
  logic [15:0]  xfer_count;
  int           n_vec = 0;
  int           n_err = 0;

  assign in_from_east  = d[0];
  assign in_from_west  = d[1];
  assign in_from_north = d[2];
  assign in_from_south = d[3];
  assign outs[0] = out_to_east;
  assign outs[1] = out_to_west;
  assign outs[2] = out_to_north;
  assign outs[3] = out_to_south;

  always #5 clk = ~clk;

  pe_relay_hs #(.DEPTH(2), .CNT_WIDTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .ap_start     (ap_start),
    .chan_en      (chan_en),
    .in_from_east (in_from_east),
    .in_from_west (in_from_west),
    .in_from_north(in_from_north),
    .in_from_south(in_from_south),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_to_east  (out_to_east),
    .out_to_west  (out_to_west),
    .out_to_north (out_to_north),
    .out_to_south (out_to_south),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .xfer_count   (xfer_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ap_start = 1'b1; chan_en = 4'hF;
    in_valid = 4'h0; out_ready = 4'hF;
    for (int c = 0; c < 4; c++) d[c] = '0;
    step(); step();
    n_vec++;
    if (in_ready !== 4'h0) begin
      n_err++;
      $display("FAIL rst_in_ready got %h want 0", in_ready);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 4'h0 || xfer_count !== 16'h0) begin
      n_err++;
      $display("FAIL rst_state ov %h cnt %h want 0 0", out_valid, xfer_count);
    end
    n_vec++;
    if (in_ready !== 4'hF) begin
      n_err++;
      $display("FAIL rst_release in_ready %h want f", in_ready);
    end
  endtask

  task automatic test_single();
    d[0] = 130'h1; in_valid = 4'b0001; out_ready = 4'hF;
    step();
    in_valid = 4'h0;
    #1;
    n_vec++;
    if (out_valid !== 4'b0001 || out_to_east !== 130'h1) begin
      n_err++;
      $display("FAIL single ov %h data %h want 1 1", out_valid, out_to_east);
    end
    step();
    n_vec++;
    if (out_valid !== 4'h0) begin
      n_err++;
      $display("FAIL single_drain ov %h want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1011;
    d[2] = 130'hA; in_valid = 4'b0100;
    #1;
    n_vec++;
    if (in_ready[2] !== 1'b1) begin
      n_err++;
      $display("FAIL bp_rdy0 got %b want 1", in_ready[2]);
    end
    step();
    d[2] = 130'hB;
    #1;
    n_vec++;
    if (in_ready[2] !== 1'b1) begin
      n_err++;
      $display("FAIL bp_rdy1 got %b want 1", in_ready[2]);
    end
    step();
    d[2] = 130'hC;
    #1;
    n_vec++;
    if (in_ready[2] !== 1'b0 || out_valid[2] !== 1'b1 || out_to_north !== 130'hA) begin
      n_err++;
      $display("FAIL bp_full rdy %b ov %b data %h want 0 1 a",
               in_ready[2], out_valid[2], out_to_north);
    end
    step();
    in_valid = 4'h0; out_ready = 4'hF;
    #1;
    n_vec++;
    if (in_ready[2] !== 1'b0 || out_to_north !== 130'hA) begin
      n_err++;
      $display("FAIL bp_hold rdy %b data %h want 0 a", in_ready[2], out_to_north);
    end
    step();
    n_vec++;
    if (out_valid[2] !== 1'b1 || out_to_north !== 130'hB || in_ready[2] !== 1'b1) begin
      n_err++;
      $display("FAIL bp_pop1 ov %b data %h rdy %b want 1 b 1",
               out_valid[2], out_to_north, in_ready[2]);
    end
    step();
    n_vec++;
    if (out_valid[2] !== 1'b0) begin
      n_err++;
      $display("FAIL bp_empty ov %b want 0", out_valid[2]);
    end
  endtask

  task automatic test_back_to_back();
    logic [129:0] prev [4];
    logic [159:0] r;
    out_ready = 4'hF; in_valid = 4'hF;
    for (int cyc = 0; cyc < 100; cyc++) begin
      for (int c = 0; c < 4; c++) begin
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        d[c] = r[129:0];
      end
      #1;
      n_vec++;
      if (in_ready !== 4'hF) begin
        n_err++;
        $display("FAIL b2b_rdy cyc %0d got %h want f", cyc, in_ready);
      end
      if (cyc > 0) begin
        for (int c = 0; c < 4; c++) begin
          n_vec++;
          if (out_valid[c] !== 1'b1 || outs[c] !== prev[c]) begin
            n_err++;
            $display("FAIL b2b_data cyc %0d ch %0d ov %b got %h want %h",
                     cyc, c, out_valid[c], outs[c], prev[c]);
          end
        end
      end
      step();
      for (int c = 0; c < 4; c++) prev[c] = d[c];
    end
    in_valid = 4'h0;
    #1;
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if (out_valid[c] !== 1'b1 || outs[c] !== prev[c]) begin
        n_err++;
        $display("FAIL b2b_last ch %0d got %h want %h", c, outs[c], prev[c]);
      end
    end
    step();
    n_vec++;
    if (out_valid !== 4'h0) begin
      n_err++;
      $display("FAIL b2b_empty ov %h want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 4'b1101;
    in_valid = 4'b0010;
    d[1] = 130'h11;
    step();
    d[1] = 130'h22;
    step();
    in_valid = 4'h0;
    #1;
    n_vec++;
    if (out_valid[1] !== 1'b1 || out_to_west !== 130'h11) begin
      n_err++;
      $display("FAIL flush_pre ov %b data %h want 1 11", out_valid[1], out_to_west);
    end
    chan_en = 4'b1101;
    #1;
    n_vec++;
    if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b0) begin
      n_err++;
      $display("FAIL flush_comb ov %b rdy %b want 0 0", out_valid[1], in_ready[1]);
    end
    step();
    chan_en = 4'hF; out_ready = 4'hF;
    #1;
    n_vec++;
    if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
      n_err++;
      $display("FAIL flush_reen ov %b rdy %b want 0 1", out_valid[1], in_ready[1]);
    end
    step();
    n_vec++;
    if (out_valid[1] !== 1'b0) begin
      n_err++;
      $display("FAIL flush_stale ov %b want 0", out_valid[1]);
    end
    d[1] = 130'h77; in_valid = 4'b0010;
    step();
    in_valid = 4'h0;
    #1;
    n_vec++;
    if (out_valid[1] !== 1'b1 || out_to_west !== 130'h77) begin
      n_err++;
      $display("FAIL flush_new ov %b data %h want 1 77", out_valid[1], out_to_west);
    end
    step();
  endtask

  task automatic test_ap_start();
    out_ready = 4'b0111;
    d[3] = 130'h55; in_valid = 4'b1000;
    step();
    ap_start = 1'b0; d[3] = 130'h66;
    #1;
    n_vec++;
    if (in_ready[3] !== 1'b0 || out_valid[3] !== 1'b1 || out_to_south !== 130'h55) begin
      n_err++;
      $display("FAIL aps_hold rdy %b ov %b data %h want 0 1 55",
               in_ready[3], out_valid[3], out_to_south);
    end
    out_ready = 4'hF;
    step();
    n_vec++;
    if (out_valid[3] !== 1'b0) begin
      n_err++;
      $display("FAIL aps_drain ov %b want 0", out_valid[3]);
    end
    ap_start = 1'b1; out_ready = 4'b0111;
    d[3] = 130'h88;
    step();
    d[3] = 130'h99;
    step();
    in_valid = 4'h0;
    reset = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 4'h0 || out_valid[3] !== 1'b1) begin
      n_err++;
      $display("FAIL aps_rst_pre rdy %h ov %b want 0 1", in_ready, out_valid[3]);
    end
    step();
    reset = 1'b0; out_ready = 4'hF;
    #1;
    n_vec++;
    if (out_valid !== 4'h0) begin
      n_err++;
      $display("FAIL aps_rst_post ov %h want 0", out_valid);
    end
  endtask

  task automatic test_stats();
    logic [15:0] exp_mid;
    logic [15:0] exp_end;
`ifdef PE_RELAY_STATS_EN
    exp_mid = 16'h0005;
    exp_end = 16'h000F;
`else
    exp_mid = 16'h0000;
    exp_end = 16'h0000;
`endif
    reset = 1'b1;
    step();
    reset = 1'b0; out_ready = 4'hF;
    d[0] = 130'h3; in_valid = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 5) begin
        n_vec++;
        if (xfer_count !== exp_mid) begin
          n_err++;
          $display("FAIL stats_mid got %h want %h", xfer_count, exp_mid);
        end
      end
    end
    in_valid = 4'h0;
    step(); step();
    n_vec++;
    if (xfer_count !== exp_end) begin
      n_err++;
      $display("FAIL stats_sat got %h want %h", xfer_count, exp_end);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_ap_start();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
